// File: rtl/volume_control.sv
// Volume control: edge-detected Up/Down steps with acceleration, saturating Volume, slew-limited Gain.
// Latency: Volume/Changed update 2 edges after Up/Down is first sampled high; Gain moves 1 LSB per RAMP_DIV cycles.
// Backpressure: none; level inputs are sampled every cycle and never stalled.
//
// Ports:
//   Clk      system clock
//   Reset    synchronous, active-high reset
//   Up/Down  debounced levels; each rising edge is one step request
//   Mute     rising edge toggles mute        (only with VOLUME_MUTE_EN)
//   Muted    current mute state              (only with VOLUME_MUTE_EN)
//   Volume   target volume setting
//   Gain     slewed gain for the DAC gain stage
//   Busy     high while Gain has not reached the target
//   Changed  one-cycle pulse when Volume takes a new value
// Optional feature macro: VOLUME_MUTE_EN (adds Mute/Muted and the mute path).

module volume_control #(
    parameter int MAX_VOL      = 255,
    parameter int DEFAULT_VOL  = 128,
    parameter int RAMP_DIV     = 50000,
    parameter int ACCEL_CYCLES = 5000000,
    parameter int ACCEL_STEP   = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Up,
    input  logic       Down,
`ifdef VOLUME_MUTE_EN
    input  logic       Mute,
    output logic       Muted,
`endif
    output logic [7:0] Volume,
    output logic [7:0] Gain,
    output logic       Busy,
    output logic       Changed
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int AW = (ACCEL_CYCLES > 0) ? $clog2(ACCEL_CYCLES + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [AW-1:0] ACCEL_SAT  = AW'(ACCEL_CYCLES);
    localparam logic [8:0]    STEP_FAST  = 9'(ACCEL_STEP);
    localparam logic [8:0]    MAX_V9     = 9'(MAX_VOL);
    localparam logic [7:0]    DEF_V      = 8'(DEFAULT_VOL);

    typedef enum logic [1:0] {
        RAMP_IDLE,
        RAMP_UP,
        RAMP_DOWN
    } ramp_state_t;

    // ------------------------------------------------------------------
    // Input register + delayed copy for edge detection
    // ------------------------------------------------------------------
    logic up_q, up_dly_q, dn_q, dn_dly_q;
    logic up_edge, dn_edge, step_acc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            up_q     <= 1'b0;
            up_dly_q <= 1'b0;
            dn_q     <= 1'b0;
            dn_dly_q <= 1'b0;
        end else begin
            up_q     <= Up;
            up_dly_q <= up_q;
            dn_q     <= Down;
            dn_dly_q <= dn_q;
        end
    end

    assign up_edge  = up_q & ~up_dly_q;
    assign dn_edge  = dn_q & ~dn_dly_q;
    // Simultaneous Up and Down edges cancel out and are not a step.
    assign step_acc = up_edge ^ dn_edge;

    // ------------------------------------------------------------------
    // Volume arithmetic with acceleration
    // ------------------------------------------------------------------
    logic [7:0]    vol_q, vol_d;
    logic [AW-1:0] accel_q, accel_d;
    logic          changed_q, changed_d;
    logic [8:0]    step_sz;
    logic [8:0]    up_sum;
    logic [7:0]    target;

    // The accel counter measures cycles since the last accepted step; a
    // saturated counter means "slow" and yields a single-LSB step.
    assign step_sz = (accel_q < ACCEL_SAT) ? STEP_FAST : 9'd1;
    // 9-bit sum so that a step near the top cannot wrap before the clamp.
    assign up_sum  = {1'b0, vol_q} + step_sz;

    always_comb begin
        vol_d = vol_q;
        if (up_edge && !dn_edge) begin
            vol_d = (up_sum > MAX_V9) ? MAX_V9[7:0] : up_sum[7:0];
        end else if (dn_edge && !up_edge) begin
            vol_d = ({1'b0, vol_q} < step_sz) ? 8'd0 : (vol_q - step_sz[7:0]);
        end

        if (step_acc) begin
            accel_d = '0;
        end else if (accel_q < ACCEL_SAT) begin
            accel_d = accel_q + 1'b1;
        end else begin
            accel_d = accel_q;
        end

        // No pulse for a step that is clamped at 0 or MAX_VOL.
        changed_d = step_acc && (vol_d != vol_q);
    end

`ifdef VOLUME_MUTE_EN
    logic mute_q, mute_dly_q, mute_edge;
    logic muted_q, muted_d;

    assign mute_edge = mute_q & ~mute_dly_q;

    // An accepted step always unmutes, even if a Mute edge arrives with it.
    always_comb begin
        muted_d = muted_q;
        if (step_acc) begin
            muted_d = 1'b0;
        end else if (mute_edge) begin
            muted_d = ~muted_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mute_q     <= 1'b0;
            mute_dly_q <= 1'b0;
            muted_q    <= 1'b0;
        end else begin
            mute_q     <= Mute;
            mute_dly_q <= mute_q;
            muted_q    <= muted_d;
        end
    end

    assign target = muted_q ? 8'd0 : vol_q;
    assign Muted  = muted_q;
`else
    assign target = vol_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vol_q     <= DEF_V;
            accel_q   <= ACCEL_SAT;
            changed_q <= 1'b0;
        end else begin
            vol_q     <= vol_d;
            accel_q   <= accel_d;
            changed_q <= changed_d;
        end
    end

    // ------------------------------------------------------------------
    // Gain slew FSM. Direction is re-derived from Gain vs target every
    // cycle, so a target change mid-ramp redirects without restarting the
    // prescaler. Reset drops Gain to 0, giving a soft start.
    // ------------------------------------------------------------------
    ramp_state_t   state_q;
    logic [PW-1:0] presc_q;
    logic [7:0]    gain_q;
    logic [7:0]    gain_nxt;

    assign gain_nxt = (gain_q < target) ? (gain_q + 8'd1) : (gain_q - 8'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            gain_q  <= 8'd0;
            presc_q <= '0;
            state_q <= (DEF_V != 8'd0) ? RAMP_UP : RAMP_IDLE;
        end else if (gain_q == target) begin
            presc_q <= '0;
            state_q <= RAMP_IDLE;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            gain_q  <= gain_nxt;
            if (gain_nxt == target) begin
                state_q <= RAMP_IDLE;
            end else if (gain_nxt < target) begin
                state_q <= RAMP_UP;
            end else begin
                state_q <= RAMP_DOWN;
            end
        end else begin
            presc_q <= presc_q + 1'b1;
            state_q <= (gain_q < target) ? RAMP_UP : RAMP_DOWN;
        end
    end

    assign Volume  = vol_q;
    assign Gain    = gain_q;
    assign Busy    = (state_q != RAMP_IDLE);
    assign Changed = changed_q;

endmodule

// File: tb/tb_volume_control.sv
// Bench for volume_control: randomized Up/Down stimulus against a time-based
// behavioural model of Volume, Changed count and settled Gain.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_volume_control;

    localparam int MAX_VOL      = 255;
    localparam int DEFAULT_VOL  = 128;
    localparam int RAMP_DIV     = 4;
    localparam int ACCEL_CYCLES = 100;
    localparam int ACCEL_STEP   = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Up = 1'b0;
    logic       Down = 1'b0;
    logic [7:0] Volume;
    logic [7:0] Gain;
    logic       Busy;
    logic       Changed;
`ifdef VOLUME_MUTE_EN
    logic       Mute = 1'b0;
    logic       Muted;
`endif

    volume_control #(
        .MAX_VOL     (MAX_VOL),
        .DEFAULT_VOL (DEFAULT_VOL),
        .RAMP_DIV    (RAMP_DIV),
        .ACCEL_CYCLES(ACCEL_CYCLES),
        .ACCEL_STEP  (ACCEL_STEP)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Up     (Up),
        .Down   (Down),
`ifdef VOLUME_MUTE_EN
        .Mute   (Mute),
        .Muted  (Muted),
`endif
        .Volume (Volume),
        .Gain   (Gain),
        .Busy   (Busy),
        .Changed(Changed)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    int chg_seen = 0;
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Changed === 1'b1) chg_seen <= chg_seen + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: volume, expected Changed pulses, time of last accepted step.
    int mvol = DEFAULT_VOL;
    int exp_chg = 0;
    int last_acc = -1;
    bit mmuted = 1'b0;

    function automatic int model_target();
        return mmuted ? 0 : mvol;
    endfunction

    task automatic model_reset();
        mvol     = DEFAULT_VOL;
        last_acc = -1;
        mmuted   = 1'b0;
    endtask

    // A step is "fast" when it rises no more than ACCEL_CYCLES cycles after the previous accepted one.
    task automatic model_accept(input bit is_up, input int rise);
        int step;
        int nv;
        step = (last_acc >= 0 && (rise - last_acc) <= ACCEL_CYCLES) ? ACCEL_STEP : 1;
        if (is_up) nv = (mvol + step > MAX_VOL) ? MAX_VOL : mvol + step;
        else       nv = (mvol < step) ? 0 : mvol - step;
        if (nv != mvol) exp_chg++;
        mvol     = nv;
        last_acc = rise;
        mmuted   = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic press(input bit u, input bit d);
        Up   = u;
        Down = d;
        if (u ^ d) model_accept(u, cyc + 1);
    endtask

    task automatic release_all();
        Up   = 1'b0;
        Down = 1'b0;
`ifdef VOLUME_MUTE_EN
        Mute = 1'b0;
`endif
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (Busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(3);
        model_reset();
        checks++; if (Volume !== 8'(DEFAULT_VOL)) begin errors++; $display("FAIL rst_volume: got %0d exp %0d", Volume, DEFAULT_VOL); end
        checks++; if (Gain !== 8'd0) begin errors++; $display("FAIL rst_gain: got %0d exp 0", Gain); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b exp 1", Busy); end
        checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL rst_changed: got %b exp 0", Changed); end
`ifdef VOLUME_MUTE_EN
        checks++; if (Muted !== 1'b0) begin errors++; $display("FAIL rst_muted: got %b exp 0", Muted); end
`endif
        Reset = 1'b0;
        tick(40);
        checks++; if (Gain !== 8'd10) begin errors++; $display("FAIL softstart_40: got %0d exp 10", Gain); end
        // Reset in the middle of the ramp restarts the soft start from 0.
        Reset = 1'b1;
        tick(1);
        checks++; if (Gain !== 8'd0) begin errors++; $display("FAIL midramp_reset: got %0d exp 0", Gain); end
        Reset = 1'b0;
        tick(511);
        checks++; if (Gain !== 8'd127 || Busy !== 1'b1) begin errors++; $display("FAIL ramp_511: got gain %0d busy %b exp 127 1", Gain, Busy); end
        tick(1);
        checks++; if (Gain !== 8'd128 || Busy !== 1'b0) begin errors++; $display("FAIL ramp_512: got gain %0d busy %b exp 128 0", Gain, Busy); end
    endtask

    task automatic test_step();
        bit ok;
        tick(50);
        press(1'b1, 1'b0);
        tick(1);
        checks++; if (Volume !== 8'(DEFAULT_VOL)) begin errors++; $display("FAIL step_lat1: got %0d exp %0d", Volume, DEFAULT_VOL); end
        tick(1);
        checks++; if (Volume !== 8'(mvol) || Changed !== 1'b1) begin errors++; $display("FAIL step_lat2: got %0d chg %b exp %0d 1", Volume, Changed, mvol); end
        tick(1);
        checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL step_pulse_width: got %b exp 0", Changed); end
        tick(7);
        release_all();
        tick(190);
        press(1'b1, 1'b0);
        tick(10);
        release_all();
        tick(5);
        checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL step_second: got %0d exp %0d", Volume, mvol); end
        checks++; if (chg_seen !== exp_chg) begin errors++; $display("FAIL step_changed_cnt: got %0d exp %0d", chg_seen, exp_chg); end
        wait_idle(ok);
        checks++; if (!ok || Gain !== 8'(model_target())) begin errors++; $display("FAIL step_gain: got %0d ok %b exp %0d", Gain, ok, model_target()); end
    endtask

    task automatic test_saturation();
        bit ok;
        for (int it = 0; it < 300 && mvol < 254; it++) begin
            tick((254 - mvol >= ACCEL_STEP) ? $urandom_range(4, 40) : $urandom_range(120, 200));
            press(1'b1, 1'b0);
            tick(3);
            release_all();
            tick(3);
            checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL climb: got %0d exp %0d", Volume, mvol); end
        end
        for (int k = 0; k < 2; k++) begin
            tick(200);
            press(1'b1, 1'b0);
            tick(3);
            release_all();
            tick(3);
            checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL top_sat: got %0d exp %0d", Volume, mvol); end
        end
        checks++; if (chg_seen !== exp_chg) begin errors++; $display("FAIL top_changed_cnt: got %0d exp %0d", chg_seen, exp_chg); end
        for (int it = 0; it < 300 && mvol > 0; it++) begin
            tick($urandom_range(4, 40));
            press(1'b0, 1'b1);
            tick(3);
            release_all();
            tick(3);
            checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL descend: got %0d exp %0d", Volume, mvol); end
        end
        tick(200);
        press(1'b0, 1'b1);
        tick(3);
        release_all();
        tick(3);
        checks++; if (Volume !== 8'd0) begin errors++; $display("FAIL bottom_sat: got %0d exp 0", Volume); end
        checks++; if (chg_seen !== exp_chg) begin errors++; $display("FAIL bottom_changed_cnt: got %0d exp %0d", chg_seen, exp_chg); end
        wait_idle(ok);
        checks++; if (!ok || Gain !== 8'(model_target())) begin errors++; $display("FAIL bottom_gain: got %0d ok %b exp %0d", Gain, ok, model_target()); end
    endtask

    task automatic test_accel();
        Reset = 1'b1;
        tick(3);
        Reset = 1'b0;
        model_reset();
        tick(20);
        press(1'b1, 1'b0);
        tick(10);
        release_all();
        checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL accel_first: got %0d exp %0d", Volume, mvol); end
        tick(40);
        press(1'b1, 1'b0);
        tick(10);
        release_all();
        checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL accel_second: got %0d exp %0d", Volume, mvol); end
        // Gap of 101 cycles is just too slow for acceleration; 100 is just fast enough.
        tick(91);
        press(1'b1, 1'b0);
        tick(10);
        release_all();
        checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL accel_gap101: got %0d exp %0d", Volume, mvol); end
        tick(90);
        press(1'b1, 1'b0);
        tick(10);
        release_all();
        checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL accel_gap100: got %0d exp %0d", Volume, mvol); end
        checks++; if (chg_seen !== exp_chg) begin errors++; $display("FAIL accel_changed_cnt: got %0d exp %0d", chg_seen, exp_chg); end
    endtask

    task automatic test_simultaneous();
        tick(150);
        press(1'b1, 1'b1);
        tick(5);
        checks++; if (Volume !== 8'(mvol) || chg_seen !== exp_chg) begin errors++; $display("FAIL both_edges: got %0d/%0d exp %0d/%0d", Volume, chg_seen, mvol, exp_chg); end
        release_all();
        tick(150);
        press(1'b1, 1'b0);
        tick(150);
        checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL held_up_step: got %0d exp %0d", Volume, mvol); end
        Down = 1'b1;
        model_accept(1'b0, cyc + 1);
        tick(5);
        checks++; if (Volume !== 8'(mvol)) begin errors++; $display("FAIL down_while_up_held: got %0d exp %0d", Volume, mvol); end
        release_all();
        tick(3);
        checks++; if (chg_seen !== exp_chg) begin errors++; $display("FAIL simul_changed_cnt: got %0d exp %0d", chg_seen, exp_chg); end
    endtask

    task automatic test_random();
        bit ok;
        int kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            tick($urandom_range(0, 1) ? $urandom_range(2, 60) : $urandom_range(110, 220));
            if (kind == 0)     press(1'b1, 1'b1);
            else if (kind < 6) press(1'b1, 1'b0);
            else               press(1'b0, 1'b1);
            tick($urandom_range(1, 6));
            release_all();
            tick(2);
            checks++; if (Volume !== 8'(mvol) || chg_seen !== exp_chg) begin errors++; $display("FAIL random_%0d: got vol %0d chg %0d exp %0d %0d", n, Volume, chg_seen, mvol, exp_chg); end
        end
        tick(3);
        wait_idle(ok);
        checks++; if (!ok || Gain !== 8'(model_target())) begin errors++; $display("FAIL random_gain: got %0d ok %b exp %0d", Gain, ok, model_target()); end
    endtask

`ifdef VOLUME_MUTE_EN
    task automatic test_mute();
        bit ok;
        Reset = 1'b1;
        tick(3);
        Reset = 1'b0;
        model_reset();
        wait_idle(ok);
        checks++; if (!ok || Gain !== 8'(DEFAULT_VOL)) begin errors++; $display("FAIL mute_pre_gain: got %0d exp %0d", Gain, DEFAULT_VOL); end
        Mute = 1'b1;
        mmuted = ~mmuted;
        tick(3);
        release_all();
        checks++; if (Muted !== 1'b1) begin errors++; $display("FAIL mute_on: got %b exp 1", Muted); end
        wait_idle(ok);
        checks++; if (!ok || Gain !== 8'(model_target()) || Volume !== 8'(mvol)) begin errors++; $display("FAIL mute_gain: got %0d vol %0d exp %0d %0d", Gain, Volume, model_target(), mvol); end
        tick(150);
        press(1'b1, 1'b0);
        tick(3);
        release_all();
        checks++; if (Muted !== 1'b0 || Volume !== 8'(mvol)) begin errors++; $display("FAIL unmute_step: got muted %b vol %0d exp 0 %0d", Muted, Volume, mvol); end
        tick(3);
        wait_idle(ok);
        checks++; if (!ok || Gain !== 8'(model_target())) begin errors++; $display("FAIL unmute_gain: got %0d exp %0d", Gain, model_target()); end
        Mute = 1'b1;
        mmuted = ~mmuted;
        tick(3);
        release_all();
        tick(150);
        Mute = 1'b1;
        press(1'b1, 1'b0);
        tick(3);
        release_all();
        checks++; if (Muted !== 1'b0 || Volume !== 8'(mvol)) begin errors++; $display("FAIL mute_vs_step: got muted %b vol %0d exp 0 %0d", Muted, Volume, mvol); end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(1);
        test_reset();
        test_step();
        test_saturation();
        test_accel();
        test_simultaneous();
        test_random();
`ifdef VOLUME_MUTE_EN
        test_mute();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
